// File: rtl/key_pulse_debouncer_if.sv
// Button/key bundle between the raw switch inputs, the debouncer and the lock FSM.
interface key_pulse_debouncer_if;
    logic [3:0] btn_raw;
    logic [3:0] keys;
    logic       held;

    modport master (output btn_raw, input keys, input held);
    modport slave  (input btn_raw, output keys, output held);
endinterface

// File: rtl/key_pulse_debouncer.sv
// 4-key debouncer: synchronizes bouncing buttons and emits a one-cycle one-hot pulse per press.
// Define KEY_REPEAT_EN to add auto-repeat pulses every REPEAT_CYCLES while a key stays held.
module key_pulse_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_CYCLES   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    key_pulse_debouncer_if.slave  bus
);
    localparam int MAXP = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
    localparam int CW   = (MAXP > 1) ? $clog2(MAXP) : 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [3:0]    r_code, w_code_nxt;
    logic [3:0]    r_sync1, r_sync;
    logic [3:0]    r_keys, w_keys_nxt;
    logic          r_held;
`ifdef KEY_REPEAT_EN
    localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_CYCLES - 1);
    logic [CW-1:0] r_rcnt, w_rcnt_nxt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync  <= '0;
            r_state <= IDLE;
            r_cnt   <= '0;
            r_code  <= '0;
            r_keys  <= '0;
            r_held  <= 1'b0;
`ifdef KEY_REPEAT_EN
            r_rcnt  <= '0;
`endif
        end else begin
            r_sync1 <= bus.btn_raw;
            r_sync  <= r_sync1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_code  <= w_code_nxt;
            r_keys  <= w_keys_nxt;
            r_held  <= (w_state_nxt == HELD);
`ifdef KEY_REPEAT_EN
            r_rcnt  <= w_rcnt_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_code_nxt  = r_code;
        w_keys_nxt  = '0;
`ifdef KEY_REPEAT_EN
        w_rcnt_nxt  = r_rcnt;
`endif
        case (r_state)
            IDLE: begin
                if ($onehot(r_sync)) begin
                    w_code_nxt  = r_sync;
                    w_cnt_nxt   = '0;
                    w_state_nxt = PRESS_WAIT;
                end else if (r_sync != 4'b0000) begin
                    // chords are never accepted; wait for all keys up first
                    w_cnt_nxt   = '0;
                    w_state_nxt = RELEASE_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (r_sync != r_code) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == DB_LAST) begin
                    w_keys_nxt  = r_code;
                    w_state_nxt = HELD;
`ifdef KEY_REPEAT_EN
                    w_rcnt_nxt  = '0;
`endif
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            HELD: begin
                if (r_sync != r_code) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = RELEASE_WAIT;
                end
`ifdef KEY_REPEAT_EN
                else if (r_rcnt == RP_LAST) begin
                    w_keys_nxt = r_code;
                    w_rcnt_nxt = '0;
                end else begin
                    w_rcnt_nxt = r_rcnt + 1'b1;
                end
`endif
            end
            RELEASE_WAIT: begin
                if (r_sync != 4'b0000) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.keys = r_keys;
    assign bus.held = r_held;
endmodule

// File: tb/tb_key_pulse_debouncer.sv
// Directed bench for key_pulse_debouncer: per-cycle compare against a run-length model plus literal pulse timings.
module tb_key_pulse_debouncer;
    localparam int D = 4;
    localparam int R = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic chk_en = 1'b0;
    always #5 clk = ~clk;

    key_pulse_debouncer_if bus();

    key_pulse_debouncer #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Model: sync is raw delayed two edges; a press is accepted once the same single
    // key has been seen on D+1 consecutive edges starting from an idle edge.
    logic [3:0] m_s1, m_s2, s, cand, key, m_keys;
    logic       m_held, down, releasing;
    int         streak, quiet, age;

    always @(posedge clk) begin
        if (reset) begin
            m_s1 = 0; m_s2 = 0; cand = 0; key = 0; m_keys = 0; m_held = 0;
            down = 0; releasing = 0; streak = 0; quiet = 0; age = 0;
        end else begin
            s = m_s2; m_s2 = m_s1; m_s1 = bus.btn_raw;
            m_keys = 0;
            if (releasing) begin
                quiet = (s == 0) ? quiet + 1 : 0;
                if (quiet == D) begin releasing = 0; cand = 0; end
            end else if (down) begin
                if (s != key) begin down = 0; releasing = 1; quiet = 0; end
`ifdef KEY_REPEAT_EN
                else begin
                    age++;
                    if (age % R == 0) m_keys = key;
                end
`endif
            end else if (cand == 0) begin
                if ($countones(s) == 1) begin cand = s; streak = 1; end
                else if (s != 0) begin releasing = 1; quiet = 0; end
            end else if (s == cand) begin
                streak++;
                if (streak == D + 1) begin
                    down = 1; key = cand; age = 0; m_keys = cand; cand = 0;
                end
            end else begin
                cand = 0;
            end
            m_held = down;
        end
    end

    logic [3:0] prev_k = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("keys_vs_model", bus.keys, m_keys);
            check("held_vs_model", bus.held, m_held);
            check("keys_onehot", int'(bus.keys == 0 || $onehot(bus.keys)), 1);
            check("no_back_to_back", int'(prev_k != 0 && bus.keys != 0), 0);
            prev_k = bus.keys;
        end
    end

    // Per-test history, index = cycle number the outputs are visible in
    int         tc;
    logic [3:0] hk[$];
    logic       hh[$];
    int         exp_c[$];
    logic [3:0] exp_k[$];

    task automatic step(input logic [3:0] b);
        bus.btn_raw = b;
        @(posedge clk);
        #1;
        tc++;
        hk.push_back(bus.keys);
        hh.push_back(bus.held);
    endtask

    task automatic hold(input logic [3:0] b, input int n);
        repeat (n) step(b);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(4'b0000);
        step(4'b0000);
        reset = 1'b0;
        tc = 0;
        hk.delete(); hh.delete(); exp_c.delete(); exp_k.delete();
        hk.push_back(4'b0000);
        hh.push_back(1'b0);
    endtask

    task automatic expect_pulse(input int c, input logic [3:0] k);
        exp_c.push_back(c);
        exp_k.push_back(k);
    endtask

    task automatic check_pulses(input string name);
        int         oc[$];
        logic [3:0] ok[$];
        for (int i = 0; i < hk.size(); i++)
            if (hk[i] != 0) begin oc.push_back(i); ok.push_back(hk[i]); end
        check({name, "_count"}, oc.size(), exp_c.size());
        for (int i = 0; i < exp_c.size() && i < oc.size(); i++) begin
            check($sformatf("%s_cycle%0d", name, i), oc[i], exp_c[i]);
            check($sformatf("%s_key%0d", name, i), ok[i], exp_k[i]);
        end
    endtask

    logic [3:0] lock_seq[4] = '{4'b0001, 4'b0100, 4'b1000, 4'b0010};

    initial begin
        int idx;
        bus.btn_raw = 4'b0000;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_keys", bus.keys, 0);
        check("reset_held", bus.held, 0);
        chk_en = 1'b1;

        // clean press
        do_reset();
        hold(4'b0001, 40);
        hold(4'b0000, 20);
        expect_pulse(7, 4'b0001);
`ifdef KEY_REPEAT_EN
        expect_pulse(23, 4'b0001);
        expect_pulse(39, 4'b0001);
`endif
        check_pulses("clean");
        check("clean_held_c6", hh[6], 0);
        check("clean_held_c7", hh[7], 1);
        check("clean_held_c42", hh[42], 1);
        check("clean_held_c43", hh[43], 0);

        // bounce then stable
        do_reset();
        for (int i = 0; i < 20; i++) step(((i / 2) % 2 == 0) ? 4'b0100 : 4'b0000);
        hold(4'b0100, 20);
        expect_pulse(27, 4'b0100);
        check_pulses("bounce");

        // chord rejected, then single key
        do_reset();
        hold(4'b1010, 20);
        hold(4'b0000, 10);
        hold(4'b1000, 15);
        hold(4'b0000, 10);
        expect_pulse(37, 4'b1000);
        check_pulses("chord");

        // lock sequence
        do_reset();
        for (int k = 0; k < 4; k++) begin
            hold(lock_seq[k], 10);
            hold(4'b0000, 10);
            expect_pulse(20 * k + 7, lock_seq[k]);
        end
        check_pulses("lock");
        idx = 0;
        for (int i = 0; i < hk.size(); i++)
            if (hk[i] != 0) idx = (idx < 4 && hk[i] == lock_seq[idx]) ? idx + 1 : 0;
        check("lock_unlock", int'(idx == 4), 1);

        // reset mid-press
        do_reset();
        hold(4'b0001, 5);
        reset = 1'b1;
        step(4'b0001);
        check("rst_press_keys_c6", bus.keys, 0);
        check("rst_press_held_c6", bus.held, 0);
        reset = 1'b0;
        hold(4'b0001, 15);
        hold(4'b0000, 10);
        expect_pulse(13, 4'b0001);
        check_pulses("rst_press");

        // reset while held
        do_reset();
        hold(4'b0010, 10);
        check("rst_held_before", bus.held, 1);
        reset = 1'b1;
        step(4'b0010);
        check("rst_held_after", bus.held, 0);
        reset = 1'b0;
        hold(4'b0010, 15);
        hold(4'b0000, 10);
        expect_pulse(7, 4'b0010);
        expect_pulse(18, 4'b0010);
        check_pulses("rst_held");

        // long hold
        do_reset();
        hold(4'b0010, 60);
        hold(4'b0000, 20);
        expect_pulse(7, 4'b0010);
`ifdef KEY_REPEAT_EN
        expect_pulse(23, 4'b0010);
        expect_pulse(39, 4'b0010);
        expect_pulse(55, 4'b0010);
`endif
        check_pulses("long");

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/key_pulse_debouncer.md
KEY_PULSE_DEBOUNCER -- requirements
Module: key_pulse_debouncer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: number of consecutive stable synchronized cycles required to accept a press or release; legal range 2..2^20.
REQ-002 Parameter REPEAT_CYCLES, default 16: auto-repeat period in cycles, used only with KEY_REPEAT_EN; legal range 2..2^20.
REQ-003 Port clk, input, 1: the single clock; all state SHALL change on its rising edge only.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port btn_raw, input, 4: asynchronous, bouncing push-button levels; 1 means pressed.
REQ-006 Port keys, output reg, 4: one-hot key pulse, high for exactly one clk cycle per accepted press; 0000 otherwise. It directly drives the keys input of the downstream lock state machine.
REQ-007 Port held, output reg, 1: high while the accepted key is in state HELD.

Function
REQ-008 btn_raw SHALL pass through a 2-flop synchronizer per bit; sync denotes the second flop, and all decisions SHALL use sync only.
REQ-009 FSM states SHALL be IDLE, PRESS_WAIT, HELD and RELEASE_WAIT, with one shared debounce counter cnt and a 4-bit register code.
REQ-010 IDLE, sync == 0000: stay in IDLE.
REQ-011 IDLE, sync has exactly one bit set: code <= sync, cnt <= 0, go to PRESS_WAIT.
REQ-012 IDLE, sync has two or more bits set: cnt <= 0, go to RELEASE_WAIT, with no pulse. Simultaneous presses are rejected.
REQ-013 PRESS_WAIT, sync != code: go to IDLE with no pulse (bounce rejected).
REQ-014 PRESS_WAIT, sync == code and cnt == DEBOUNCE_CYCLES-1: keys <= code for one cycle, go to HELD.
REQ-015 PRESS_WAIT, sync == code otherwise: cnt increments.
REQ-016 HELD, sync != code (release or extra key pressed): cnt <= 0, go to RELEASE_WAIT; keys stays 0000.
REQ-017 RELEASE_WAIT, sync != 0000: cnt <= 0 and stay.
REQ-018 RELEASE_WAIT, sync == 0000: cnt increments; at cnt == DEBOUNCE_CYCLES-1, go to IDLE.
REQ-019 Latency: btn_raw stable with a single key from cycle 0 SHALL give keys high in cycle DEBOUNCE_CYCLES+3 only. With the defaults this is cycle 7.
REQ-020 keys SHALL be 0000 or one-hot in every cycle, and SHALL never be high in two consecutive cycles.
REQ-021 held SHALL be 1 exactly in the cycles where the state is HELD, including the cycle in which the first pulse is high.
REQ-022 Counters SHALL be sized with $clog2 of the larger parameter, and SHALL never wrap within a state.

Reset
REQ-023 While reset is high at a clk edge, the following SHALL be loaded: state = IDLE, cnt = 0, code = 0000, repeat counter = 0, synchronizer flops = 0000, keys = 0000, held = 0.
REQ-024 Reset SHALL override every other condition in the same cycle.
REQ-025 Reset mid-press discards the press. A key still held when reset is released SHALL be treated as a new press and produce one pulse after the full REQ-019 latency.

Configuration
REQ-026 Macro KEY_REPEAT_EN defined: in HELD, a repeat counter is cleared on entry and increments each cycle. At REPEAT_CYCLES-1 it SHALL assert keys <= code for one cycle and clear, so pulses recur every REPEAT_CYCLES cycles while the key is held.
REQ-027 Macro KEY_REPEAT_EN undefined: there SHALL be no repeat counter logic, and exactly one pulse per press regardless of hold time.

Verification
REQ-028 Clean press: btn_raw=0001 from cycle 0, held 40 cycles, then released. Required: keys=0001 only in cycle 7 (defaults), held high cycles 7..~42; without KEY_REPEAT_EN no further pulse.
REQ-029 Bounce: btn_raw toggles 0100/0000 every 2 cycles for 20 cycles, then 0100 stable. Required: no pulse during bouncing; exactly one 0100 pulse 7 cycles after the input becomes stable.
REQ-030 Simultaneous keys: btn_raw=1010 for 20 cycles, then 0000, then 1000. Required: no pulse for 1010; one 1000 pulse after DEBOUNCE_CYCLES release plus REQ-019 latency.
REQ-031 Lock sequence: presses 0001, 0100, 1000, 0010 each held 10 cycles with 10-cycle gaps. Required: exactly four one-hot pulses in that order; the downstream lock asserts unlock.
REQ-032 Reset mid-operation: assert reset in cycle 5 of a 0001 press while btn_raw stays 0001. Required: outputs are 0 in cycle 6, and one 0001 pulse DEBOUNCE_CYCLES+3 cycles after reset is released.
REQ-033 With KEY_REPEAT_EN and defaults: hold 0010 for 60 cycles. Required: pulses in cycles 7, 23, 39 and 55 only.
